// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative unsigned integer square root, one root bit per clock.
// Returns floor(sqrt(x)) and remainder x - y^2 through a valid/ack handshake.
`timescale 1ns/1ps
module sqrt_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x_in,
  input  logic               x_valid,
  output logic               x_ready,
  output logic [WIDTH/2-1:0] y_out,
  output logic [WIDTH/2:0]   r_out,
  output logic               y_valid,
  input  logic               y_ack
);

  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b;
  logic             last;
  logic             load;

  assign x_ready = (state_q == IDLE);
  assign last    = (state_q == CALC) && (cnt_q == CW'(N - 1));
  assign load    = ((state_q == IDLE) && x_valid) || (state_q == CALC);

  always_comb begin
    b      = root_q | mask_q;
    rem_d  = rem_q;
    root_d = root_q;
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE) begin
      rem_d  = x_in;
      root_d = '0;
      mask_d = WIDTH'(1) << (WIDTH - 2);
      cnt_d  = '0;
    end else if (state_q == CALC) begin
      // rem >= root|mask cannot underflow; root shifts right as mask walks down
      if (rem_q >= b) begin
        rem_d  = rem_q - b;
        root_d = (root_q >> 1) | mask_q;
      end else begin
        root_d = root_q >> 1;
      end
      mask_d = mask_q >> 2;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      root_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      y_out   <= '0;
      r_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      if (load) begin
        rem_q  <= rem_d;
        root_q <= root_d;
        mask_q <= mask_d;
        cnt_q  <= cnt_d;
      end
      case (state_q)
        IDLE: begin
          if (x_valid) state_q <= CALC;
        end
        CALC: begin
          if (last) begin
            y_out   <= root_d[N-1:0];
            r_out   <= rem_d[N:0];
            y_valid <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (y_ack) begin
            y_valid <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed vectors plus randomized regression for sqrt_iter.
// Instances at WIDTH 16, 8, 2 and 32 share one clock.
`timescale 1ns/1ps
module tb_sqrt_iter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a [4];
  logic        x_v   [4];
  logic        ack   [4];
  logic        rdy_w [4];
  logic        vld_w [4];
  logic [31:0] y_w   [4];
  logic [31:0] r_w   [4];

  logic [15:0] x16;
  logic [7:0]  x8;
  logic [1:0]  x2;
  logic [31:0] x32;
  logic [7:0]  y16;
  logic [8:0]  r16;
  logic [3:0]  y8;
  logic [4:0]  r8;
  logic [0:0]  y2;
  logic [1:0]  r2;
  logic [15:0] y32;
  logic [16:0] r32;

  assign y_w[0] = 32'(y16);
  assign r_w[0] = 32'(r16);
  assign y_w[1] = 32'(y8);
  assign r_w[1] = 32'(r8);
  assign y_w[2] = 32'(y2);
  assign r_w[2] = 32'(r2);
  assign y_w[3] = 32'(y32);
  assign r_w[3] = 32'(r32);

  sqrt_iter #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst_a[0]), .x_in(x16), .x_valid(x_v[0]),
    .x_ready(rdy_w[0]), .y_out(y16), .r_out(r16),
    .y_valid(vld_w[0]), .y_ack(ack[0]));
  sqrt_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst_a[1]), .x_in(x8), .x_valid(x_v[1]),
    .x_ready(rdy_w[1]), .y_out(y8), .r_out(r8),
    .y_valid(vld_w[1]), .y_ack(ack[1]));
  sqrt_iter #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst_a[2]), .x_in(x2), .x_valid(x_v[2]),
    .x_ready(rdy_w[2]), .y_out(y2), .r_out(r2),
    .y_valid(vld_w[2]), .y_ack(ack[2]));
  sqrt_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst_a[3]), .x_in(x32), .x_valid(x_v[3]),
    .x_ready(rdy_w[3]), .y_out(y32), .r_out(r32),
    .y_valid(vld_w[3]), .y_ack(ack[3]));

  int checks = 0;
  int errors = 0;
  int nlat [4];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // reference: floor(sqrt(x)) via real arithmetic then exact integer fix-up
  task automatic model(input longint x, output longint y, output longint r);
    y = longint'($rtoi($floor($sqrt(real'(x)))));
    while (y * y > x) y--;
    while ((y + 1) * (y + 1) <= x) y++;
    r = x - y * y;
  endtask

  task automatic set_x(input int k, input longint x);
    case (k)
      0: x16 = x[15:0];
      1: x8  = x[7:0];
      2: x2  = x[1:0];
      default: x32 = x[31:0];
    endcase
  endtask

  task automatic op(input int k, input longint x, input int ackdly,
                    output longint y, output longint r, output int lat);
    int g;
    bit moved;
    g = 0;
    moved = 0;
    @(negedge clk);
    while (!rdy_w[k] && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("ready_timeout", 0, 1);
    set_x(k, x);
    x_v[k] = 1'b1;
    @(negedge clk);
    x_v[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vld_w[k] && lat < 100);
    y = longint'(y_w[k]);
    r = longint'(r_w[k]);
    repeat (ackdly) begin
      @(negedge clk);
      if (!vld_w[k] || longint'(y_w[k]) != y || longint'(r_w[k]) != r)
        moved = 1;
    end
    if (ackdly > 0) chk("hold_stable", moved, 0);
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    chk("valid_drop", vld_w[k], 0);
  endtask

  typedef struct {
    int     k;
    longint x;
    longint y;
    longint r;
  } vec_t;

  task automatic run_rand(input int k, input int n, input longint xmax);
    longint x, y, r, ey, er;
    int lat;
    for (int i = 0; i < n; i++) begin
      x = longint'({$urandom, $urandom}) & xmax;
      if ($urandom_range(0, 15) == 0) x = xmax;
      if ($urandom_range(0, 15) == 0) x = 0;
      op(k, x, int'($urandom_range(0, 4)), y, r, lat);
      model(x, ey, er);
      chk("rand_y", y, ey);
      chk("rand_r", r, er);
      chk("rand_r_le_2y", longint'(r <= 2 * y), 1);
      chk("rand_lat", lat, nlat[k]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t   vt[$];
    longint y, r;
    int     lat;
    bit     bad;
    nlat[0] = 8;
    nlat[1] = 4;
    nlat[2] = 1;
    nlat[3] = 16;
    for (int k = 0; k < 4; k++) begin
      rst_a[k] = 1'b1;
      x_v[k]   = 1'b0;
      ack[k]   = 1'b0;
    end
    x16 = 16'd144;
    x8 = '0;
    x2 = '0;
    x32 = '0;
    x_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) rst_a[k] = 1'b0;
    x_v[0] = 1'b0;
    chk("rst_ready", rdy_w[0], 1);
    chk("rst_valid", vld_w[0], 0);
    chk("rst_y", y_w[0], 0);
    chk("rst_r", r_w[0], 0);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("idle_after_rst", rdy_w[0], 1);

    vt.push_back('{0, 0, 0, 0});
    vt.push_back('{0, 1, 1, 0});
    vt.push_back('{0, 144, 12, 0});
    vt.push_back('{0, 143, 11, 22});
    vt.push_back('{0, 65535, 255, 510});
    vt.push_back('{1, 200, 14, 4});
    vt.push_back('{1, 255, 15, 30});
    vt.push_back('{2, 3, 1, 2});
    foreach (vt[i]) begin
      op(vt[i].k, vt[i].x, 0, y, r, lat);
      chk($sformatf("vec%0d_y", i), y, vt[i].y);
      chk($sformatf("vec%0d_r", i), r, vt[i].r);
      chk($sformatf("vec%0d_lat", i), lat, nlat[vt[i].k]);
    end

    // operand changes and stray x_valid while busy must be ignored
    @(negedge clk);
    x16 = 16'd1000;
    x_v[0] = 1'b1;
    @(negedge clk);
    bad = 0;
    lat = 0;
    while (!vld_w[0] && lat < 50) begin
      if (rdy_w[0]) bad = 1;
      x16 = 16'(lat * 77 + 5);
      x_v[0] = lat[0];
      @(negedge clk);
      lat++;
    end
    x_v[0] = 1'b0;
    chk("busy_ready_low", bad, 0);
    chk("k1000_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      chk("k1000_y", y_w[0], 31);
      chk("k1000_r", r_w[0], 39);
      chk("k1000_valid", vld_w[0], 1);
      chk("k1000_ready", rdy_w[0], 0);
      @(negedge clk);
    end
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("ack_ready", rdy_w[0], 1);
    chk("ack_valid", vld_w[0], 0);
    chk("ack_y_kept", y_w[0], 31);
    chk("ack_r_kept", r_w[0], 39);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld_w[0] || !rdy_w[0]) bad = 1;
    end
    chk("single_result", bad, 0);

    // reset on the 4th CALC edge abandons the computation
    x16 = 16'd50000;
    x_v[0] = 1'b1;
    @(negedge clk);
    x_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("midcalc_busy", rdy_w[0], 0);
    rst_a[0] = 1'b1;
    @(negedge clk);
    rst_a[0] = 1'b0;
    chk("midrst_ready", rdy_w[0], 1);
    chk("midrst_valid", vld_w[0], 0);
    chk("midrst_y", y_w[0], 0);
    chk("midrst_r", r_w[0], 0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld_w[0]) bad = 1;
    end
    chk("midrst_no_result", bad, 0);
    op(0, 4, 1, y, r, lat);
    chk("after_rst_y", y, 2);
    chk("after_rst_r", r, 0);
    chk("after_rst_lat", lat, 8);

    fork
      run_rand(0, 3000, 64'hFFFF);
      run_rand(3, 1500, 64'hFFFF_FFFF);
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
